// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel integer clock divider.
package clk_div_pkg;

  localparam int DEF_DIV_RATIO_WIDTH = 4;
  localparam int MAX_CH              = 8;

  // Length of the high phase of a divided period: floor(N/2).
  function automatic logic [31:0] half_ratio(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, boundary-latched ratio/enable,
// registered divided clock and tick, and the bypass mux to the reference clock.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int W = DEF_DIV_RATIO_WIDTH
) (
  input  logic         i_ref_clk,
  input  logic         i_rst,
  input  logic         i_clk_en,
  input  logic [W-1:0] i_div_ratio,
  input  logic         i_sync,
  output logic         o_div_clk,
  output logic         o_tick,
  output logic         o_active
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] r_lat;
  logic         en_lat;
  logic         div_q;
  logic         tick_q;
  logic         bypass;
  logic         load;
  logic         start_div;

  assign bypass    = !en_lat || (r_lat < W'(2));
  assign cnt_nxt   = cnt + W'(1);
  // Ratio/enable are only sampled here, so a running phase is never cut short
  // except by an explicit sync.
  assign load      = (cnt == r_lat - W'(1)) || bypass || i_sync;
  assign start_div = i_clk_en && (i_div_ratio >= W'(2));

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt    <= '0;
      r_lat  <= '0;
      en_lat <= 1'b0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
    end else if (load) begin
      cnt    <= '0;
      r_lat  <= i_div_ratio;
      en_lat <= i_clk_en;
      div_q  <= start_div;
      tick_q <= start_div;
    end else begin
      cnt    <= cnt_nxt;
      tick_q <= 1'b0;
      div_q  <= (32'(cnt_nxt) < half_ratio(32'(r_lat)));
    end
  end

  assign o_div_clk = bypass ? i_ref_clk : div_q;
  assign o_tick    = tick_q && !bypass;
  assign o_active  = !bypass;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent integer clock dividers sharing one reference clock;
// i_sync restarts every channel's period on the same edge.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int DIV_RATIO_WIDTH = DEF_DIV_RATIO_WIDTH
) (
  input  logic                              i_ref_clk,
  input  logic                              i_rst,
  input  logic [NUM_CH-1:0]                 i_clk_en,
  input  logic [NUM_CH*DIV_RATIO_WIDTH-1:0] i_div_ratio,
  input  logic                              i_sync,
  output logic [NUM_CH-1:0]                 o_div_clk,
  output logic [NUM_CH-1:0]                 o_tick,
  output logic [NUM_CH-1:0]                 o_active
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    clk_div_chan #(
      .W(DIV_RATIO_WIDTH)
    ) u_chan (
      .i_ref_clk  (i_ref_clk),
      .i_rst      (i_rst),
      .i_clk_en   (i_clk_en[c]),
      .i_div_ratio(i_div_ratio[c*DIV_RATIO_WIDTH +: DIV_RATIO_WIDTH]),
      .i_sync     (i_sync),
      .o_div_clk  (o_div_clk[c]),
      .o_tick     (o_tick[c]),
      .o_active   (o_active[c])
    );
  end

endmodule
